// File: rtl/lsq_unit_if.sv
// Handshake bundle around the load/store queue: execute-stage push port,
// data-memory request/response port and register-file write-back port.
interface lsq_unit_if #(
  parameter int C_XLEN = 32
);
  logic              exs_lq_wr_i;
  logic              exs_sq_wr_i;
  logic [2:0]        exs_funct3_i;
  logic [4:0]        exs_regd_addr_i;
  logic [C_XLEN-1:0] exs_regs2_data_i;
  logic [C_XLEN-1:0] exs_addr_i;
  logic              lsq_full_o;
  logic              dmem_req_o;
  logic              dmem_ack_i;
  logic              dmem_wr_o;
  logic [C_XLEN-1:0] dmem_addr_o;
  logic [3:0]        dmem_byte_en_o;
  logic [C_XLEN-1:0] dmem_wr_data_o;
  logic              dmem_rd_valid_i;
  logic [C_XLEN-1:0] dmem_rd_data_i;
  logic              wb_regd_wr_o;
  logic [4:0]        wb_regd_addr_o;
  logic [C_XLEN-1:0] wb_regd_data_o;

  modport slave (
    input  exs_lq_wr_i, exs_sq_wr_i, exs_funct3_i, exs_regd_addr_i,
    input  exs_regs2_data_i, exs_addr_i,
    output lsq_full_o,
    output dmem_req_o, dmem_wr_o, dmem_addr_o, dmem_byte_en_o, dmem_wr_data_o,
    input  dmem_ack_i, dmem_rd_valid_i, dmem_rd_data_i,
    output wb_regd_wr_o, wb_regd_addr_o, wb_regd_data_o
  );

  modport master (
    output exs_lq_wr_i, exs_sq_wr_i, exs_funct3_i, exs_regd_addr_i,
    output exs_regs2_data_i, exs_addr_i,
    input  lsq_full_o,
    input  dmem_req_o, dmem_wr_o, dmem_addr_o, dmem_byte_en_o, dmem_wr_data_o,
    output dmem_ack_i, dmem_rd_valid_i, dmem_rd_data_i,
    input  wb_regd_wr_o, wb_regd_addr_o, wb_regd_data_o
  );
endinterface

// File: rtl/lsq_unit.sv
// In-order load/store queue: buffers committed memory ops in a small FIFO and
// issues them one at a time to the data memory, writing load results back.

module lsq_unit_chk (
  input logic clk_i,
  input logic resetb_i,
  input logic clk_en_i,
  input logic lq_wr_i,
  input logic sq_wr_i,
  input logic full_i
);
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!resetb_i)
    !(clk_en_i && (lq_wr_i || sq_wr_i) && full_i));

  a_single_strobe: assert property (@(posedge clk_i) disable iff (!resetb_i)
    !(lq_wr_i && sq_wr_i));
endmodule

module lsq_unit #(
  parameter int C_XLEN  = 32,
  parameter int C_DEPTH = 4
) (
  input logic       clk_i,
  input logic       resetb_i,
  input logic       clk_en_i,
  lsq_unit_if.slave bus
);
  localparam int PTR_W = $clog2(C_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              is_store;
    logic [2:0]        funct3;
    logic [4:0]        regd_addr;
    logic [C_XLEN-1:0] addr;
    logic [C_XLEN-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_WAIT_RD = 2'b10
  } state_t;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [C_XLEN-1:0] lane_data(input logic [1:0] size,
                                                  input logic [C_XLEN-1:0] data);
    logic [C_XLEN-1:0] res;
    case (size)
      2'b00:   res = {4{data[7:0]}};
      2'b01:   res = {2{data[15:0]}};
      default: res = data;
    endcase
    return res;
  endfunction

  // Halfwords shift by addr[1] only; the unaligned low bit is ignored.
  function automatic logic [C_XLEN-1:0] load_extract(input logic [2:0] funct3,
                                                     input logic [1:0] off,
                                                     input logic [C_XLEN-1:0] raw);
    logic [C_XLEN-1:0] sh;
    logic [C_XLEN-1:0] res;
    case (funct3[1:0])
      2'b00:   sh = raw >> {off, 3'b000};
      2'b01:   sh = raw >> {off[1], 4'b0000};
      default: sh = raw;
    endcase
    case (funct3)
      3'b000:  res = {{(C_XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  res = {{(C_XLEN-16){sh[15]}}, sh[15:0]};
      3'b100:  res = {{(C_XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  res = {{(C_XLEN-16){1'b0}}, sh[15:0]};
      3'b010:  res = raw;
      default: res = '0;
    endcase
    return res;
  endfunction

  entry_t            mem_r [C_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  state_t            state_r;
  state_t            state_nxt_s;
  entry_t            head_s;
  entry_t            push_entry_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              req_s;
  logic              ack_s;
  logic              rd_done_s;
  logic              wb_wr_r;
  logic [4:0]        wb_addr_r;
  logic [C_XLEN-1:0] wb_data_r;

  assign full_s    = (count_r == CNT_W'(C_DEPTH));
  assign head_s    = mem_r[rd_ptr_r];
  assign req_s     = (state_r == ST_REQ);
  assign push_s    = (bus.exs_lq_wr_i | bus.exs_sq_wr_i) & ~full_s;
  assign ack_s     = req_s & bus.dmem_ack_i;
  assign rd_done_s = (state_r == ST_WAIT_RD) & bus.dmem_rd_valid_i;
  assign pop_s     = (ack_s & head_s.is_store) | rd_done_s;

  assign push_entry_s = '{is_store:  bus.exs_sq_wr_i,
                          funct3:    bus.exs_funct3_i,
                          regd_addr: bus.exs_regd_addr_i,
                          addr:      bus.exs_addr_i,
                          data:      bus.exs_regs2_data_i};

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Issue sequencing: one outstanding access, back-to-back when entries remain.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (push_s || (count_r != CNT_W'(0))) state_nxt_s = ST_REQ;
        else                                  state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (ack_s) begin
          if (!head_s.is_store)                  state_nxt_s = ST_WAIT_RD;
          else if (count_nxt_s != CNT_W'(0))     state_nxt_s = ST_REQ;
          else                                   state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT_RD: begin
        if (rd_done_s) begin
          if (count_nxt_s != CNT_W'(0)) state_nxt_s = ST_REQ;
          else                          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_RD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, pointers and occupancy.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_r  <= ST_IDLE;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clk_en_i) begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
    end
  end

  // Entry storage; contents are meaningful only between the pointers.
  always_ff @(posedge clk_i) begin
    if (clk_en_i && push_s) mem_r[wr_ptr_r] <= push_entry_s;
  end

  // Registered write-back; address and data hold until the next load returns.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wb_wr_r   <= 1'b0;
      wb_addr_r <= 5'd0;
      wb_data_r <= '0;
    end else if (clk_en_i) begin
      wb_wr_r <= rd_done_s;
      if (rd_done_s) begin
        wb_addr_r <= head_s.regd_addr;
        wb_data_r <= load_extract(head_s.funct3, head_s.addr[1:0], bus.dmem_rd_data_i);
      end
    end
  end

  assign bus.lsq_full_o     = full_s;
  assign bus.dmem_req_o     = req_s;
  assign bus.dmem_wr_o      = req_s & head_s.is_store;
  assign bus.dmem_addr_o    = req_s ? {head_s.addr[C_XLEN-1:2], 2'b00} : '0;
  assign bus.dmem_byte_en_o = req_s ? lane_be(head_s.funct3[1:0], head_s.addr[1:0]) : 4'b0000;
  assign bus.dmem_wr_data_o = req_s ? lane_data(head_s.funct3[1:0], head_s.data) : '0;
  assign bus.wb_regd_wr_o   = wb_wr_r;
  assign bus.wb_regd_addr_o = wb_addr_r;
  assign bus.wb_regd_data_o = wb_data_r;

  lsq_unit_chk u_chk (
    .clk_i    (clk_i),
    .resetb_i (resetb_i),
    .clk_en_i (clk_en_i),
    .lq_wr_i  (bus.exs_lq_wr_i),
    .sq_wr_i  (bus.exs_sq_wr_i),
    .full_i   (full_s)
  );
endmodule

// File: doc/lsq_unit.md
Name: lsq_unit

Overview:
- Load/store queue downstream of the execute stage.
- Accepts committed load and store requests, buffers them in order in a small FIFO, and issues them one at a time to the data-memory port.
- Returns load results, aligned and sign/zero-extended, on a write-back port to the register file.
- Back-pressures the execute stage via `lsq_full_o`.

Parameters:
- C_XLEN, 32, data/address width (only 32 supported).
- C_DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock
- resetb_i  in  1  reset
- clk_en_i  in  1  global clock enable; gates every state update
- exs_lq_wr_i  in  1  push load entry (single-cycle strobe)
- exs_sq_wr_i  in  1  push store entry (never asserted together with exs_lq_wr_i)
- exs_funct3_i  in  3  RV32I load/store funct3
- exs_regd_addr_i  in  5  load destination register
- exs_regs2_data_i  in  C_XLEN  store data
- exs_addr_i  in  C_XLEN  effective byte address
- lsq_full_o  out  1  count == C_DEPTH
- dmem_req_o  out  1  memory request valid
- dmem_ack_i  in  1  request accepted this cycle
- dmem_wr_o  out  1  1 = store, 0 = load
- dmem_addr_o  out  C_XLEN  word address (addr[1:0] forced to 0)
- dmem_byte_en_o  out  4  byte lanes
- dmem_wr_data_o  out  C_XLEN  lane-replicated store data
- dmem_rd_valid_i  in  1  load data valid
- dmem_rd_data_i  in  C_XLEN  raw word read
- wb_regd_wr_o  out  1  write-back strobe (one cycle)
- wb_regd_addr_o  out  5  write-back register
- wb_regd_data_o  out  C_XLEN  extended load result

Behaviour:
- Reset: resetb_i is asynchronous, active-low; clock clk_i.
  - In reset: rd/wr pointers = 0, count = 0, FSM = IDLE.
  - Outputs in reset: lsq_full_o = 0, dmem_req_o = 0, dmem_wr_o = 0, wb_regd_wr_o = 0, wb_regd_addr_o = 0, wb_regd_data_o = 0.
  - Reset mid-transaction abandons the in-flight access and all queued entries.
- Entry contents: {is_store, funct3, regd_addr, addr, data}.
- Push: on a clk_en_i cycle with either write strobe, write the entry at wr_ptr and increment wr_ptr (wraps modulo C_DEPTH).
  - A push while full is ignored and is an assertion error; the upstream stage never does this, because it stalls on lsq_full_o.
- Pop: rd_ptr increments and the entry retires when:
  - a store is acked (dmem_req_o & dmem_ack_i), or
  - a load's dmem_rd_valid_i is seen.
- Simultaneous push and pop: count unchanged; both pointers advance.
- lsq_full_o is registered-count-based combinational: count == C_DEPTH.
  - A pop in cycle N deasserts it in cycle N+1.
- FSM states:
  - IDLE: count != 0 goes to REQ.
  - REQ: dmem_req_o = 1, with fields driven from the head entry.
    - Ack on a store: go to IDLE (or stay in REQ if count - 1 != 0 after the pop; the next entry is issued back-to-back).
    - Ack on a load: go to WAIT_RD.
  - WAIT_RD: dmem_req_o = 0; only one outstanding access.
    - On dmem_rd_valid_i: pop, then go to REQ if more entries remain, else IDLE.
- Request stability: dmem_req_o and its fields stay stable until ack. Ack is ignored while dmem_req_o = 0.
- Lane mapping (off = addr[1:0]):
  - Byte (funct3[1:0] = 00): be = 0001 << off; data = {4{rs2[7:0]}}.
  - Half (01): be = 0011 << (addr[1]*2); data = {2{rs2[15:0]}}; addr[0] ignored.
  - Word (10): be = 1111; data = rs2; addr[1:0] ignored.
  - Misalignment exceptions are not raised here.
- Load extraction:
  - Shift dmem_rd_data_i right by 8*off (half uses addr[1] only).
  - funct3 000 LB, 001 LH: sign-extend.
  - 100 LBU, 101 LHU: zero-extend.
  - 010 LW: unchanged.
  - Other funct3 values: result 0.
- Write-back: registered.
  - The cycle after rd_valid, wb_regd_wr_o = 1 for exactly one cycle, with address and data held until the next write-back.
  - Latency from push into an empty queue to dmem_req_o is 1 cycle; load write-back is 1 cycle after rd_valid.
- clk_en_i = 0: all registers hold and wb_regd_wr_o keeps its value. Memory-side inputs arriving in that cycle are ignored.

Test Plan:
- Reset, then push SW addr 0x100 data 0xDEADBEEF; ack in 2nd REQ cycle -> dmem_req_o held 2 cycles, be = 1111, addr = 0x100, count returns to 0.
- Push SB addr 0x203 data 0x000000A5 -> be = 1000, wr_data = 0xA5A5A5A5, addr = 0x200.
- LB from 0x302 with rd_data 0x00800000 -> wb_regd_data = 0xFFFFFF80; LBU -> 0x00000080; wb_regd_wr_o high exactly 1 cycle after rd_valid, regd_addr echoed.
- LH from 0x402 with rd_data 0x8001xxxx -> 0xFFFF8001; LHU -> 0x00008001.
- Push 4 entries with ack held low -> lsq_full_o = 1 after 4th push; on first ack, lsq_full_o = 0 next cycle; entries issue in push order.
- Push and pop in the same cycle while count = 2 -> count stays 2; assert resetb_i low during WAIT_RD -> all outputs 0 immediately, queue empty, later rd_valid ignored.
